// File: rtl/hr_inject_q_pkg.sv
// hr_inject_q_pkg
//   Shared flit definitions for the HR-ring injection queues. The flit width
//   and the idle-flit value are defined once here as macros, then wrapped as
//   typed package items.
//   No ports (package).
`ifndef HR_INJECT_Q_DEFINES
`define HR_INJECT_Q_DEFINES
`define CONTROL_W 144
`define HR_IDLE_FLIT {`CONTROL_W{1'b0}}
`endif

package hr_inject_q_pkg;

  localparam int FLIT_W = `CONTROL_W;

  typedef logic [FLIT_W-1:0] flit_t;

  // Flit value driven on a ring port when its queue is empty.
  localparam flit_t IDLE_FLIT = `HR_IDLE_FLIT;

endpackage

// File: rtl/hr_inj_fifo.sv
// hr_inj_fifo
//   One injection queue. It holds DEPTH flits in FIFO order and presents the
//   head flit to a ring port. It also tracks how long the head flit has waited
//   without an ack.
//   Ports:
//     clk, rst    rising-edge clock and synchronous active-high reset
//     push_i      enqueue request; ignored when the queue is full
//     flit_i      flit to enqueue
//     ready_o     queue is not full (registered occupancy, no pop bypass)
//     pop_i       ring port accepted the head flit; ignored when empty
//     head_o      head flit, or the idle flit when the queue is empty
//     starve_o    head flit has waited STARVE_LIM cycles
//     occ_o       current entry count
module hr_inj_fifo
  import hr_inject_q_pkg::*;
#(
  parameter int DEPTH      = 4,   // power of two, >= 2
  parameter int STARVE_LIM = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  flit_t                    flit_i,
  output logic                     ready_o,
  input  logic                     pop_i,
  output flit_t                    head_o,
  output logic                     starve_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(STARVE_LIM + 1);

  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);
  localparam logic [CW-1:0] LIM_CNT  = CW'(STARVE_LIM);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [CW-1:0] wait_q, wait_d;
  flit_t         mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push_i && (occ_q != FULL_OCC);
  assign do_pop  = pop_i  && (occ_q != '0);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    wait_d   = wait_q;

    // Pointers wrap for free because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;  // idle, or push and pop cancel out
    endcase

    // The wait count restarts with every new head (ack) and while empty.
    if ((occ_q == '0) || pop_i)  wait_d = '0;
    else if (wait_q != LIM_CNT)  wait_d = wait_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      wait_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      wait_q   <= wait_d;
    end
  end

  // NOTE: storage is deliberately not reset. A cleared occupancy already
  // masks stale entries, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= flit_i;
  end

  assign ready_o  = (occ_q != FULL_OCC);
  assign head_o   = (occ_q != '0) ? mem_q[rd_ptr_q] : IDLE_FLIT;
  assign starve_o = (wait_q == LIM_CNT);
  assign occ_o    = occ_q;

endmodule

// File: rtl/hr_inject_q.sv
// hr_inject_q
//   Local-client injection stage for an HRnode. enq_sel_i steers an offered
//   flit into one of two independent queues. Queue 0 drives port0_local_o and
//   queue 1 drives port1_local_o.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     enq_flit_i/enq_valid_i        flit offered by the local client
//     enq_sel_i                     0 -> queue 0 / port0, 1 -> queue 1 / port1
//     enq_ready0_o/enq_ready1_o     queue is not full
//     port0_local_o/port1_local_o   head flit toward HRnode (idle when empty)
//     portl0_ack/portl1_ack         HRnode accepted the presented flit
//     starve0_o/starve1_o           head flit waited STARVE_LIM cycles
//     occ0_o/occ1_o                 queue occupancy
module hr_inject_q
  import hr_inject_q_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`CONTROL_W-1:0]   enq_flit_i,
  input  logic                    enq_valid_i,
  input  logic                    enq_sel_i,
  output logic                    enq_ready0_o,
  output logic                    enq_ready1_o,
  output logic [`CONTROL_W-1:0]   port0_local_o,
  output logic [`CONTROL_W-1:0]   port1_local_o,
  input  logic                    portl0_ack,
  input  logic                    portl1_ack,
  output logic                    starve0_o,
  output logic                    starve1_o,
  output logic [$clog2(DEPTH):0]  occ0_o,
  output logic [$clog2(DEPTH):0]  occ1_o
);

  hr_inj_fifo #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) u_q0 (
    .clk      (clk),
    .rst      (rst),
    .push_i   (enq_valid_i && !enq_sel_i),
    .flit_i   (enq_flit_i),
    .ready_o  (enq_ready0_o),
    .pop_i    (portl0_ack),
    .head_o   (port0_local_o),
    .starve_o (starve0_o),
    .occ_o    (occ0_o)
  );

  hr_inj_fifo #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) u_q1 (
    .clk      (clk),
    .rst      (rst),
    .push_i   (enq_valid_i && enq_sel_i),
    .flit_i   (enq_flit_i),
    .ready_o  (enq_ready1_o),
    .pop_i    (portl1_ack),
    .head_o   (port1_local_o),
    .starve_o (starve1_o),
    .occ_o    (occ1_o)
  );

endmodule

// File: tb/tb_hr_inject_q.sv
// tb_hr_inject_q
//   Directed bench for hr_inject_q (DEPTH=4, STARVE_LIM=64). The stimulus
//   pushes each flit it expects to be accepted into a per-port expected queue.
//   A monitor pops that queue and compares it with the port whenever an ack
//   meets a non-empty queue. Occupancy, ready, starve and idle outputs are
//   checked directly against hand-derived values.
module tb_hr_inject_q;
  import hr_inject_q_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_LIM = 64;
  localparam int OW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  flit_t         enq_flit;
  logic          enq_valid;
  logic          enq_sel;
  logic          enq_ready0, enq_ready1;
  flit_t         port0, port1;
  logic          ack0, ack1;
  logic          starve0, starve1;
  logic [OW-1:0] occ0, occ1;

  int checks = 0;
  int errors = 0;

  flit_t exp0 [$];
  flit_t exp1 [$];

  hr_inject_q #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .enq_flit_i    (enq_flit),
    .enq_valid_i   (enq_valid),
    .enq_sel_i     (enq_sel),
    .enq_ready0_o  (enq_ready0),
    .enq_ready1_o  (enq_ready1),
    .port0_local_o (port0),
    .port1_local_o (port1),
    .portl0_ack    (ack0),
    .portl1_ack    (ack1),
    .starve0_o     (starve0),
    .starve1_o     (starve1),
    .occ0_o        (occ0),
    .occ1_o        (occ1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input flit_t got, input flit_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic flit_t mk(input int n);
    return {16'hC0DE, 112'h0, 16'(n)};
  endfunction

  // One clock of stimulus. Inputs change #1 after a rising edge and return to
  // idle once the edge has consumed them.
  task automatic cyc(input logic v, input logic sel, input flit_t f,
                     input logic a0, input logic a1);
    enq_valid = v;
    enq_sel   = sel;
    enq_flit  = f;
    ack0      = a0;
    ack1      = a1;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
  endtask

  // Accepted enqueue: the expected value is queued for the monitor.
  task automatic enq(input logic sel, input flit_t f);
    if (sel) exp1.push_back(f);
    else     exp0.push_back(f);
    cyc(1'b1, sel, f, 1'b0, 1'b0);
  endtask

  // Monitor: on the falling edge, an ack against a non-empty queue means the
  // presented head is consumed at the next rising edge.
  always @(negedge clk) begin
    if (!rst && ack0 && occ0 != '0) begin
      if (exp0.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop0_unexpected: got %h, expected nothing", port0);
      end else check("pop0", port0, exp0.pop_front());
    end
    if (!rst && ack1 && occ1 != '0) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop1_unexpected: got %h, expected nothing", port1);
      end else check("pop1", port1, exp1.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_sel = 1'b0; enq_flit = '0;
    ack0 = 1'b0; ack1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_port0",  port0, '0);
    check("rst_port1",  port1, '0);
    check("rst_ready0", flit_t'(enq_ready0), 1);
    check("rst_ready1", flit_t'(enq_ready1), 1);
    check("rst_occ0",   flit_t'(occ0), 0);
    check("rst_starve0", flit_t'(starve0), 0);

    // Single enqueue into queue 0, visible after one edge
    enq(1'b0, flit_t'(16'h1851));
    check("enq_port0", port0, flit_t'(16'h1851));
    check("enq_port1", port1, '0);
    check("enq_occ0",  flit_t'(occ0), 1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("deq_occ0",  flit_t'(occ0), 0);
    check("deq_idle0", port0, '0);

    // Fill queue 1, overflow offer, drain in order
    for (int i = 0; i < 4; i++) enq(1'b1, mk(16'h100 + i));
    check("full_ready1", flit_t'(enq_ready1), 0);
    check("full_occ1",   flit_t'(occ1), 4);
    check("full_ready0", flit_t'(enq_ready0), 1);
    cyc(1'b1, 1'b1, mk(16'h1FF), 1'b0, 1'b0);
    check("ovf_occ1",  flit_t'(occ1), 4);
    check("ovf_head1", port1, mk(16'h100));
    check("ovf_port0", port0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("drain_idle1", port1, '0);
    check("drain_occ1",  flit_t'(occ1), 0);

    // Full queue 0: enqueue alongside ack is refused (no pop bypass)
    for (int i = 0; i < 4; i++) enq(1'b0, mk(16'h200 + i));
    cyc(1'b1, 1'b0, mk(16'h2FF), 1'b1, 1'b0);
    check("fullack_occ0",   flit_t'(occ0), 3);
    check("fullack_ready0", flit_t'(enq_ready0), 1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("two_occ0", flit_t'(occ0), 2);
    exp0.push_back(mk(16'h204));
    cyc(1'b1, 1'b0, mk(16'h204), 1'b1, 1'b0);
    check("pushpop_occ0", flit_t'(occ0), 2);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("order_occ0", flit_t'(occ0), 0);

    // Starvation: rises on the 64th unacked wait cycle, single ack clears
    enq(1'b0, mk(16'h300));
    repeat (STARVE_LIM - 1) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("starve0_pre", flit_t'(starve0), 0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("starve0_rise", flit_t'(starve0), 1);
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("starve0_hold", flit_t'(starve0), 1);
    check("starve1_quiet", flit_t'(starve1), 0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("starve0_clear", flit_t'(starve0), 0);

    // Mid-operation reset discards both queues; reset-cycle enq/ack ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, mk(16'h400 + i), 1'b0, 1'b0);
      cyc(1'b1, 1'b1, mk(16'h500 + i), 1'b0, 1'b0);
    end
    check("pre_rst_occ0", flit_t'(occ0), 3);
    check("pre_rst_occ1", flit_t'(occ1), 3);
    rst = 1'b1;
    cyc(1'b1, 1'b1, mk(16'h5FF), 1'b1, 1'b1);
    rst = 1'b0;
    check("mrst_port0",  port0, '0);
    check("mrst_port1",  port1, '0);
    check("mrst_occ0",   flit_t'(occ0), 0);
    check("mrst_occ1",   flit_t'(occ1), 0);
    check("mrst_ready0", flit_t'(enq_ready0), 1);
    check("mrst_ready1", flit_t'(enq_ready1), 1);
    check("mrst_starve0", flit_t'(starve0), 0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("emptyack_occ0", flit_t'(occ0), 0);
    check("emptyack_occ1", flit_t'(occ1), 0);

    // Every expected flit must have been seen leaving its port
    check("left0", flit_t'(exp0.size()), 0);
    check("left1", flit_t'(exp1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hr_inject_q.md
HR_INJECT_Q -- requirements
Module: hr_inject_q

Interface
REQ-001 Parameter DEPTH, default 4, gives the entries per injection queue; it SHALL be a power of two, minimum 2.
REQ-002 Parameter STARVE_LIM, default 64, gives the cycles a head flit may wait unacked before a starve flag is raised.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enq_flit_i  input  `control_w (144)  flit offered by the local client.
REQ-006 enq_valid_i  input  1  enq_flit_i is valid this cycle.
REQ-007 enq_sel_i  input  1  target ring port for the offered flit: 0 selects port0, 1 selects port1.
REQ-008 enq_ready0_o / enq_ready1_o  output  1 each  queue 0 / queue 1 is not full.
REQ-009 port0_local_o / port1_local_o  output  `control_w each  head flit, driving HRnode port0_local_i / port1_local_i.
REQ-010 portl0_ack / portl1_ack  input  1 each  HRnode accepted the flit presented on that port this cycle.
REQ-011 starve0_o / starve1_o  output  1 each  head of that queue has waited STARVE_LIM cycles.
REQ-012 occ0_o / occ1_o  output  $clog2(DEPTH)+1  current entry count of that queue.

Function
REQ-013 The block SHALL hold two independent FIFOs, queue 0 feeding port0 and queue 1 feeding port1.
REQ-014 An enqueue SHALL occur at the clock edge when enq_valid_i=1 and enq_ready of the queue named by enq_sel_i is 1.
REQ-015 When enq_valid_i=1 and the selected queue is full, no state SHALL change and the client SHALL hold the flit.
REQ-016 enq_readyN_o SHALL equal (occN != DEPTH) using the registered occupancy, with no pop bypass: a full queue with an ack this cycle still reports not-ready.
REQ-017 portN_local_o SHALL be the head entry when occN > 0, and all-zero (idle flit) when occN = 0; the output is driven from registers with no combinational path from enq_*.
REQ-018 Enqueue-to-output latency SHALL be 1 cycle: a flit written into an empty queue at edge t appears on portN_local_o after edge t.
REQ-019 portlN_ack=1 while occN>0 SHALL pop the head at the next edge; portlN_ack while occN=0 SHALL be ignored.
REQ-020 A simultaneous enqueue and pop on the same queue SHALL leave occN unchanged and preserve FIFO order.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy SHALL be tracked separately so that full and empty are unambiguous.
REQ-022 Each queue SHALL keep a wait counter that increments each cycle with occN>0 and portlN_ack=0, saturates at STARVE_LIM, and clears on an ack or when occN=0.
REQ-023 starveN_o SHALL be 1 exactly when the wait counter of queue N equals STARVE_LIM.
REQ-024 The two queues SHALL be fully independent; activity on one SHALL NOT affect the other's outputs.

Reset
REQ-025 On rst=1 at an edge: pointers, occupancies and wait counters SHALL clear to 0; portN_local_o SHALL read 0; enq_readyN_o SHALL read 1; starveN_o SHALL read 0.
REQ-026 Reset asserted mid-operation SHALL discard all queued flits, and an enqueue or ack in the reset cycle SHALL be ignored.
REQ-027 FIFO storage contents need not be reset.

Structure
REQ-028 `control_w, the flit width (144) and the idle-flit value SHALL come from the shared defines file.
REQ-029 One sub-module, hr_inj_fifo (DEPTH, STARVE_LIM), SHALL implement a single queue with its wait counter, and SHALL be instantiated twice.
REQ-030 hr_inject_q SHALL contain only the enq_sel_i steering and the port wiring.

Verification
REQ-031 After reset, enqueue flit 0x...1851 with sel=0 -> port0_local_o=0x...1851 after 1 cycle; port1_local_o=0; occ0=1.
REQ-032 Fill queue 1 with 4 flits with no ack -> enq_ready1_o=0 and occ1=4; a 5th offer is not accepted; then ack for 4 cycles -> the flits emerge in order, followed by an idle 0.
REQ-033 Queue 0 full plus ack plus enq_valid with sel=0 in the same cycle -> no enqueue and occ0 drops to 3; with occ0=2, enqueue plus ack -> occ0 stays 2 and order is preserved.
REQ-034 Hold a head flit unacked with STARVE_LIM=64 -> starve0_o rises on the 64th wait cycle and stays high; a single ack clears it the next cycle.
REQ-035 Assert rst with both queues holding 3 flits -> next cycle both outputs are 0, occupancies are 0, ready is 1 and starve is 0; an ack with an empty queue leaves occ at 0.
